pp_decimator_m: RTL

Generic polyphase decimate-by-M FIR for the DDC chain, replacing fixed-factor decimators.
- Accepts one sample per `valid_in`.
- Every M accepted samples, computes one N = M·L tap output with a single time-shared multiply-accumulator, where L is taps per phase.
- Has a bypass mode, a busy indication and sticky overrun detection.
- Sits after the mixer / earlier decimation stages; its output feeds the next stage or the output FIFO.

---
 rtl/pp_decim_pkg.sv | 56 +++++
 rtl/pp_decim_mac.sv | 48 ++++
 rtl/pp_decimator_m.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pp_decim_pkg.sv
// pp_decim_pkg: shared types and helpers for the polyphase decimator.
// Holds the FSM state enum, the accumulator width rule and round/saturate.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef COEFF_WIDTH_DDC
`define COEFF_WIDTH_DDC 16
`endif
`ifndef COEFFS_PP_M
`define COEFFS_PP_M { \
  16'd16, 16'd15, 16'd14, 16'd13, \
  16'd12, 16'd11, 16'd10, 16'd9,  \
  16'd8,  16'd7,  16'd6,  16'd5,  \
  16'd4,  16'd3,  16'd2,  16'd1 }
`endif

package pp_decim_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_e;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int n
  );
    return dw + cw + $clog2(n);
  endfunction

  // Round half up after dropping sh fraction bits,
  // then clamp to a dw-bit signed range.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] a,
    input int                 sh,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (sh > 0)
      r = (a + (64'sd1 <<< (sh - 1))) >>> sh;
    else
      r = a;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi)
      r = hi;
    else if (r < lo)
      r = lo;
    return r;
  endfunction

endpackage

// File: rtl/pp_decim_mac.sv
// pp_decim_mac: registered signed MAC with clear/enable.
// Ports: clk, arst_n, i_clr, i_en, i_x, i_h -> o_y (acc or requantised).
// Macro PP_DECIM_REQUANT_EN selects round/saturate to DW on o_y.
module pp_decim_mac
  import pp_decim_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 36,
  parameter int OW = 36
)(
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [CW-1:0] i_h,
  output logic signed [OW-1:0] o_y
);

  logic signed [DW+CW-1:0] w_prod;
  logic signed [AW-1:0]    w_ext;
  logic signed [AW-1:0]    r_acc;

  assign w_prod = i_x * i_h;
  assign w_ext  = {{(AW-DW-CW){w_prod[DW+CW-1]}}, w_prod};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      r_acc <= '0;
    else if (i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= r_acc + w_ext;
  end

`ifdef PP_DECIM_REQUANT_EN
  logic signed [63:0] w_a64;
  logic signed [63:0] w_q64;

  assign w_a64 = {{(64-AW){r_acc[AW-1]}}, r_acc};
  assign w_q64 = round_sat(w_a64, CW - 1, DW);
  assign o_y   = w_q64[OW-1:0];
`else
  assign o_y = r_acc;
`endif

endmodule

// File: rtl/pp_decimator_m.sv
// pp_decimator_m: polyphase decimate-by-M FIR, N=M*L taps, one shared MAC.
// Ports: clk, arst_n, bypass, data_in/valid_in in; data_out/valid_out,
// busy, overrun out; overrun_clr in. Macro PP_DECIM_REQUANT_EN requantises.
module pp_decimator_m
  import pp_decim_pkg::*;
#(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int COEFF_WIDTH    = `COEFF_WIDTH_DDC,
  parameter int DECIM_FACTOR   = 4,
  parameter int TAPS_PER_PHASE = 4,
  parameter logic [DECIM_FACTOR*TAPS_PER_PHASE*COEFF_WIDTH-1:0]
                COEFFS         = `COEFFS_PP_M,
  localparam int N         = DECIM_FACTOR * TAPS_PER_PHASE,
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, N),
`ifdef PP_DECIM_REQUANT_EN
  localparam int OUT_WIDTH = DATA_WIDTH
`else
  localparam int OUT_WIDTH = ACC_WIDTH
`endif
)(
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        bypass,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                        valid_in,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        valid_out,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = COEFF_WIDTH;
  localparam int TW = $clog2(N);
  localparam int PW = $clog2(DECIM_FACTOR);
  localparam logic [TW-1:0] T_LAST = TW'(N - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DECIM_FACTOR - 1);

  logic signed [DW-1:0]        r_x  [N];
  logic signed [DW-1:0]        r_sh [N];
  logic [PW-1:0]               r_ph;
  logic [TW-1:0]               r_t;
  state_e                      r_state;
  logic                        r_odone;
  logic                        r_vout;
  logic                        r_ovr;
  logic signed [OUT_WIDTH-1:0] r_dout;

  logic                        w_frame;
  logic                        w_clr;
  logic                        w_en;
  logic signed [CW-1:0]        w_h;
  logic signed [DW-1:0]        w_s;
  logic signed [OUT_WIDTH-1:0] w_y;
  logic signed [OUT_WIDTH-1:0] w_byp;

  assign w_frame = valid_in && (r_ph == P_LAST);
  assign w_clr   = w_frame && (r_state == S_IDLE);
  assign w_en    = (r_state == S_MAC);
  assign w_h     = COEFFS[32'(r_t)*CW +: CW];
  assign w_s     = r_sh[r_t];

  pp_decim_mac #(
    .DW (DW),
    .CW (CW),
    .AW (ACC_WIDTH),
    .OW (OUT_WIDTH)
  ) u_mac (
    .clk    (clk),
    .arst_n (arst_n),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_x    (w_s),
    .i_h    (w_h),
    .o_y    (w_y)
  );

  // Sample line keeps shifting in bypass so filtering resumes cleanly.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < N; k++) begin
        r_x[k]  <= '0;
        r_sh[k] <= '0;
      end
      r_ph <= '0;
    end else begin
      if (valid_in) begin
        r_x[0] <= data_in;
        for (int k = 1; k < N; k++)
          r_x[k] <= r_x[k-1];
        r_ph <= (r_ph == P_LAST) ? '0 : r_ph + 1'b1;
      end
      if (w_clr) begin
        r_sh[0] <= data_in;
        for (int k = 1; k < N; k++)
          r_sh[k] <= r_x[k-1];
      end
    end
  end

  // OUT lasts two cycles: register/strobe, then a turnaround
  // cycle that still counts as busy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_odone <= 1'b0;
      r_vout  <= 1'b0;
      r_ovr   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_vout <= 1'b0;
      if (w_frame && (r_state != S_IDLE))
        r_ovr <= 1'b1;
      else if (overrun_clr)
        r_ovr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_frame) begin
            r_t     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_t     <= r_t + 1'b1;
          r_odone <= 1'b0;
          if (r_t == T_LAST)
            r_state <= S_OUT;
        end
        S_OUT: begin
          if (!r_odone) begin
            r_odone <= 1'b1;
            if (!bypass) begin
              r_dout <= w_y;
              r_vout <= 1'b1;
            end
          end else begin
            r_odone <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PP_DECIM_REQUANT_EN
  assign w_byp = data_in;
`else
  assign w_byp = {{(OUT_WIDTH-DW-CW+1){data_in[DW-1]}},
                  data_in, {(CW-1){1'b0}}};
`endif

  assign data_out  = bypass ? w_byp : r_dout;
  assign valid_out = bypass ? valid_in : r_vout;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_ovr;

endmodule
